// File: rtl/wvlt_obuf.sv
// Wavelet output buffer: packs (l,h) coefficient pairs from the slow core beat into a
// word buffer and replays the stored frame at full clock rate. Optional macro: WVLT_OBUF_SWAP_EN.
module wvlt_obuf #(
   parameter  int pW_DAT     = 16,
   parameter  int pWORDS_DAT = 128,
   localparam int pADR_DAT   = $clog2(pWORDS_DAT)
) (
   input  logic                iclk,
   input  logic                irst_n,
   input  logic                iclk_ena,
   input  logic                iena,
   input  logic [pW_DAT-1:0]   idat_l,
   input  logic [pW_DAT-1:0]   idat_h,
   input  logic                ireq,
   output logic                ordy,
   output logic [pADR_DAT:0]   olen,
   output logic                oena,
   output logic [pW_DAT-1:0]   odat,
   output logic                oovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      READY = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam logic [pADR_DAT:0] cFULL = (pADR_DAT+1)'(pWORDS_DAT);

   state_t                r_state;
   state_t                w_state_nxt;

   logic [pW_DAT-1:0]     r_mem [pWORDS_DAT];

   logic [pADR_DAT:0]     r_wr_cnt;
   logic [pADR_DAT:0]     r_olen;
   logic [pADR_DAT-1:0]   r_rd_adr;
   logic                  r_hold_vld;
   logic [pW_DAT-1:0]     r_hold;
   logic                  r_ovf;

   logic                  r_iss_d1;
   logic [pW_DAT-1:0]     r_rd_dat;
   logic                  r_oena;
   logic [pW_DAT-1:0]     r_odat;

   logic                  w_beat;
   logic                  w_can_write;
   logic                  w_accept;
   logic                  w_drop;
   logic                  w_end;
   logic                  w_can_read;
   logic                  w_issue;
   logic                  w_last;
   logic [pW_DAT-1:0]     w_first;
   logic [pW_DAT-1:0]     w_second;
   logic                  w_mem_we;
   logic [pADR_DAT-1:0]   w_mem_adr;
   logic [pW_DAT-1:0]     w_mem_din;

`ifdef WVLT_OBUF_SWAP_EN
   assign w_first  = idat_h;
   assign w_second = idat_l;
`else
   assign w_first  = idat_l;
   assign w_second = idat_h;
`endif

   // A beat takes the write port for two cycles: first word now, held word on the next cycle.
   assign w_beat      = iclk_ena & iena;
   assign w_can_write = (r_state == IDLE) || (r_state == FILL);
   assign w_accept    = w_beat & w_can_write & (r_wr_cnt != cFULL);
   assign w_drop      = w_beat & ~w_accept;
   assign w_end       = iclk_ena & ~iena & (r_state == FILL);

   assign w_can_read  = (r_state == READY) || (r_state == DRAIN);
   assign w_issue     = ireq & w_can_read;
   assign w_last      = w_issue & ({1'b0, r_rd_adr} == (r_olen - (pADR_DAT+1)'(1)));

   always_comb begin
      w_mem_we  = 1'b0;
      w_mem_adr = r_wr_cnt[pADR_DAT-1:0];
      w_mem_din = w_first;
      if (r_hold_vld) begin
         w_mem_we  = 1'b1;
         w_mem_adr = r_wr_cnt[pADR_DAT-1:0] + pADR_DAT'(1);
         w_mem_din = r_hold;
      end else if (w_accept) begin
         w_mem_we  = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = FILL;
         FILL:    if (w_end)    w_state_nxt = READY;
         READY:   if (w_issue)  w_state_nxt = w_last ? IDLE : DRAIN;
         DRAIN:   if (w_last)   w_state_nxt = IDLE;
         default:               w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         r_state    <= IDLE;
         r_wr_cnt   <= '0;
         r_olen     <= '0;
         r_rd_adr   <= '0;
         r_hold_vld <= 1'b0;
         r_hold     <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_hold_vld <= w_accept;
         if (w_accept) begin
            r_hold <= w_second;
         end
         if (r_hold_vld) begin
            r_wr_cnt <= r_wr_cnt + (pADR_DAT+1)'(2);
         end
         // Length is latched at frame end; the write counter restarts for the next frame.
         if (w_end) begin
            r_olen   <= r_wr_cnt;
            r_wr_cnt <= '0;
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
         if (w_issue) begin
            r_rd_adr <= w_last ? '0 : r_rd_adr + pADR_DAT'(1);
         end
      end
   end

   always_ff @(posedge iclk) begin
      if (w_mem_we) begin
         r_mem[w_mem_adr] <= w_mem_din;
      end
   end

   // Two-stage read: registered memory output, then output register holding the last valid word.
   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         r_iss_d1 <= 1'b0;
         r_rd_dat <= '0;
         r_oena   <= 1'b0;
         r_odat   <= '0;
      end else begin
         r_iss_d1 <= w_issue;
         if (w_issue) begin
            r_rd_dat <= r_mem[r_rd_adr];
         end
         r_oena <= r_iss_d1;
         if (r_iss_d1) begin
            r_odat <= r_rd_dat;
         end
      end
   end

   assign ordy = w_can_read;
   assign olen = r_olen;
   assign oena = r_oena;
   assign odat = r_odat;
   assign oovf = r_ovf;

endmodule

// File: tb/tb_wvlt_obuf.sv
// Directed bench for wvlt_obuf: fill/drain, paced drain, overflow, collision, mid-drain reset.
// Expected word order follows WVLT_OBUF_SWAP_EN when that macro is defined.
module tb_wvlt_obuf;
   localparam int W     = 16;
   localparam int DEPTH = 128;
   localparam int AW    = 7;

   logic          iclk = 1'b0;
   logic          irst_n;
   logic          iclk_ena;
   logic          iena;
   logic [W-1:0]  idat_l;
   logic [W-1:0]  idat_h;
   logic          ireq;
   logic          ordy;
   logic [AW:0]   olen;
   logic          oena;
   logic [W-1:0]  odat;
   logic          oovf;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  last_dat = '0;

   always #5 iclk = ~iclk;

   wvlt_obuf #(.pW_DAT(W), .pWORDS_DAT(DEPTH)) dut (
      .iclk(iclk), .irst_n(irst_n), .iclk_ena(iclk_ena), .iena(iena),
      .idat_l(idat_l), .idat_h(idat_h), .ireq(ireq),
      .ordy(ordy), .olen(olen), .oena(oena), .odat(odat), .oovf(oovf)
   );

   task automatic step();
      @(posedge iclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [W-1:0] l, input logic [W-1:0] h, input bit push);
      iclk_ena = 1'b1;
      iena     = 1'b1;
      idat_l   = l;
      idat_h   = h;
      step();
      iclk_ena = 1'b0;
      idat_l   = '0;
      idat_h   = '0;
      step();
      if (push) begin
`ifdef WVLT_OBUF_SWAP_EN
         exp_q.push_back(h);
         exp_q.push_back(l);
`else
         exp_q.push_back(l);
         exp_q.push_back(h);
`endif
      end
   endtask

   task automatic end_frame(input int len);
      iclk_ena = 1'b1;
      iena     = 1'b0;
      step();
      iclk_ena = 1'b0;
      chk("end_ordy", 32'(ordy), 32'd1);
      chk("end_olen", 32'(olen), 32'(len));
      step();
   endtask

   // Output seen after the edge closing cycle c reflects the issue made in cycle c-1.
   task automatic drain(input int len, input bit toggle);
      int         issued = 0;
      bit         prev   = 1'b0;
      bit         iss;
      logic [W-1:0] e;
      for (int c = 0; c < 2*len + 4; c++) begin
         ireq = toggle ? (c % 2 == 0) : 1'b1;
         iss  = ireq && (issued < len);
         step();
         chk("drain_oena", 32'(oena), 32'(prev));
         if (prev) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            chk("drain_odat", 32'(odat), 32'(e));
            last_dat = e;
         end
         if (iss) begin
            issued++;
            chk("drain_ordy", 32'(ordy), 32'(issued < len));
         end
         prev = iss;
      end
      ireq = 1'b0;
      chk("odat_hold", 32'(odat), 32'(last_dat));
   endtask

   initial begin
      irst_n = 1'b0; iclk_ena = 1'b0; iena = 1'b0;
      idat_l = '0;   idat_h = '0;     ireq = 1'b0;
      step();
      step();
      chk("rst_ordy", 32'(ordy), 32'd0);
      chk("rst_olen", 32'(olen), 32'd0);
      chk("rst_oena", 32'(oena), 32'd0);
      chk("rst_odat", 32'(odat), 32'd0);
      chk("rst_oovf", 32'(oovf), 32'd0);
      irst_n = 1'b1;
      step();

      // Basic frame, continuous request.
      beat(16'd1, 16'd2, 1'b1);
      beat(16'd3, 16'd4, 1'b1);
      beat(16'd5, 16'd6, 1'b1);
      end_frame(6);
      drain(6, 1'b0);

      // Same frame, request toggling.
      beat(16'd1, 16'd2, 1'b1);
      beat(16'd3, 16'd4, 1'b1);
      beat(16'd5, 16'd6, 1'b1);
      end_frame(6);
      drain(6, 1'b1);

      // Collision while READY.
      beat(16'd9, 16'd10, 1'b1);
      end_frame(2);
      beat(16'h00AA, 16'h00BB, 1'b0);
      chk("coll_oovf", 32'(oovf), 32'd1);
      chk("coll_ordy", 32'(ordy), 32'd1);
      chk("coll_olen", 32'(olen), 32'd2);
      drain(2, 1'b0);

      // Reset in the middle of a drain.
      beat(16'd1, 16'd2, 1'b1);
      beat(16'd3, 16'd4, 1'b1);
      end_frame(4);
      ireq = 1'b1;
      step();
      step();
      chk("pre_rst_oena", 32'(oena), 32'd1);
      chk("pre_rst_odat", 32'(odat), 32'(exp_q[0]));
      irst_n = 1'b0;
      ireq   = 1'b0;
      step();
      chk("mid_rst_ordy", 32'(ordy), 32'd0);
      chk("mid_rst_oena", 32'(oena), 32'd0);
      chk("mid_rst_odat", 32'(odat), 32'd0);
      chk("mid_rst_olen", 32'(olen), 32'd0);
      chk("mid_rst_oovf", 32'(oovf), 32'd0);
      irst_n = 1'b1;
      exp_q.delete();
      step();
      beat(16'd7, 16'd8, 1'b1);
      end_frame(2);
      drain(2, 1'b0);

      // Overflow: 65 beats into a 128-word buffer.
      for (int k = 0; k < 64; k++) begin
         beat(16'(2*k + 1), 16'(2*k + 2), 1'b1);
      end
      chk("ovf_before", 32'(oovf), 32'd0);
      beat(16'hFFFF, 16'hEEEE, 1'b0);
      chk("ovf_after", 32'(oovf), 32'd1);
      end_frame(128);
      drain(128, 1'b0);
      chk("ovf_sticky", 32'(oovf), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/wvlt_obuf.md
Name: wvlt_obuf

Overview:
- Output-side counterpart of the wavelet input buffer. Collects low/high coefficient pairs that the wavelet core emits once per slow clock-enable beat (2 MHz).
- Stores each pair into an on-chip buffer as two consecutive words. On downstream request, replays the frame at full iclk rate (128 MHz) as a single-word stream.
- Sits between the wavelet core output and the sample-rate consumer (reconstruction or packer logic).

Parameters:
- pW_DAT, 16, width of one coefficient word (l and h have equal width).
- pWORDS_DAT, 128, buffer depth in words; must be a power of two, ≥4.
- pADR_DAT, $clog2(pWORDS_DAT), address width; derived, not overridden.

Ports:
- iclk  in  1  system clock, 128 MHz.
- irst_n  in  1  synchronous reset, active low.
- iclk_ena  in  1  core beat strobe; one-cycle pulse, strobes spaced ≥2 iclk apart.
- iena  in  1  core frame valid; sampled only on iclk_ena cycles.
- idat_l  in  pW_DAT  low-band coefficient; valid on iclk_ena cycles.
- idat_h  in  pW_DAT  high-band coefficient; valid on iclk_ena cycles.
- ireq  in  1  downstream read request; sampled every iclk.
- ordy  out  1  a complete frame is stored and not yet fully read.
- olen  out  pADR_DAT+1  stored frame length in words; valid while ordy=1.
- oena  out  1  odat valid qualifier.
- odat  out  pW_DAT  output word stream.
- oovf  out  1  sticky overflow/collision flag.

Behaviour:
- Reset (irst_n=0 at posedge iclk): state IDLE; wr_cnt=0, rd_adr=0; ordy=0, olen=0, oena=0, odat=0, oovf=0. Buffer contents are don't-care. Reset mid-fill or mid-drain abandons the frame; read pipeline outputs are forced to 0 on the next edge.
- States:
  - IDLE: waiting for a frame.
  - FILL: collecting pairs.
  - READY: frame stored, ordy=1.
  - DRAIN: reading out, ordy=1.
- Write beat (iclk_ena=1 & iena=1, in IDLE or FILL):
  - Cycle T: write idat_l to mem[wr_cnt]; register idat_h.
  - Cycle T+1: write the held h to mem[wr_cnt+1]; wr_cnt += 2.
  - IDLE moves to FILL on the first beat.
- Full: when wr_cnt = pWORDS_DAT, further beats are dropped (no write, no count change) and oovf is set.
- Frame end: iclk_ena=1 & iena=0 in FILL → olen <= wr_cnt, state READY, ordy=1 on the next cycle. iclk_ena cycles with iena=0 in IDLE are ignored.
- Collision: beat with iena=1 arriving in READY or DRAIN → beat dropped, oovf set, stored frame unaffected.
- Drain:
  - In READY or DRAIN, each cycle with ireq=1 issues read address rd_adr and increments it.
  - ireq=0 pauses; rd_adr holds and oena deasserts in the matching output cycle.
  - READY moves to DRAIN on the first issued read.
- Read latency: 2 iclk (registered memory output, then output register). Address issued at cycle N → odat/oena at N+2. oena is the ireq-issue flag delayed by 2.
- Last read (rd_adr = olen-1 issued):
  - Next state IDLE; ordy=0 and rd_adr=0 from the next cycle.
  - A new frame may begin writing immediately; in-flight reads are unaffected.
- ireq in IDLE/FILL: ignored, no read issued, oena stays 0.
- oena=0 does not zero odat; odat holds its last value.
- oovf clears only on reset.

Optional Feature:
- Macro WVLT_OBUF_SWAP_EN.
- Defined: each pair is stored h-first (mem[wr_cnt]=h, mem[wr_cnt+1]=l); the output stream is h0,l0,h1,l1,...
- Undefined: l-first order, stream l0,h0,l1,h1,...
- Latency, lengths and flags are identical in both builds.

Test Plan:
- 3 beats (l,h)=(1,2),(3,4),(5,6) with iena=1, then a strobe with iena=0 → ordy=1, olen=6. Hold ireq=1 for 6 cycles → oena high 6 cycles, odat=1,2,3,4,5,6 starting 2 cycles after ireq; ordy=0 after the last issue.
- Same frame, ireq toggled 1,0,1,0,… → 6 valid words in order with gaps matching ireq, no duplicates or skips.
- 65 beats with depth 128 → olen=128, oovf=1; drain returns the first 64 pairs only.
- New beat with iena=1 while in READY → frame drains unchanged, oovf=1.
- irst_n=0 for 1 cycle mid-drain → next cycle ordy=0, oena=0, odat=0, olen=0. Then a fresh 1-beat frame (7,8) drains as 7,8.
- WVLT_OBUF_SWAP_EN build with beats (1,2),(3,4) → odat=2,1,4,3.
